// File: rtl/nbody_sched_if.sv
// Register bus between a host (master) and the nbody_sched control block (slave).
interface nbody_sched_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (output chipselect, read, write, addr, writedata, input readdata);
  modport slave  (input chipselect, read, write, addr, writedata, output readdata);
endinterface

// File: rtl/nbody_sched.sv
// N-body step scheduler: all-pairs accel issue, velocity/position strobes via fixed-latency delay lines.
// Optional macro NBODY_SCHED_IRQ_EN adds the IRQ_EN register (index 5) and a live irq output.
module nbody_sched #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int ACCEL_LAT  = 78,
  parameter int POS_LAT    = 21,
  localparam int BW        = $clog2(BODIES)
)(
  input  logic          clk,
  input  logic          rst,
  nbody_sched_if.slave  bus,
  output logic [BW-1:0] pair_i,
  output logic [BW-1:0] pair_j,
  output logic          pair_valid,
  output logic          pair_last,
  output logic [BW-1:0] v_wr_addr,
  output logic          v_wren,
  output logic [BW-1:0] pos_rd_addr,
  output logic          pos_rd_valid,
  output logic [BW-1:0] pos_wr_addr,
  output logic          pos_wren,
  output logic          first_step,
  output logic          irq
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_ADRAIN = 3'd2;
  localparam logic [2:0] S_POS    = 3'd3;
  localparam logic [2:0] S_PDRAIN = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]            state;
  logic                  go, done, err;
  logic [BW:0]           n_bodies, n_m1, n_clamp;
  logic [15:0]           steps, step_count, steps_eff;
  logic [BW-1:0]         ci, cj;
  logic                  wr, rd, wr_ctrl, ack, abort, busy, ci_last, cj_last;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [ACCEL_LAT:1]         v_vld;
  logic [ACCEL_LAT:1][BW-1:0] v_adr;
  logic [POS_LAT:1]           p_vld;
  logic [POS_LAT:1][BW-1:0]   p_adr;

  logic unused_addr;
  assign unused_addr = ^bus.addr[ADDR_WIDTH-1:3];

  assign wr        = bus.chipselect & bus.write;
  assign rd        = bus.chipselect & bus.read;
  assign wr_ctrl   = wr && (bus.addr[2:0] == 3'd0);
  assign ack       = wr_ctrl && bus.writedata[1];
  assign abort     = wr_ctrl && !bus.writedata[0] && (state != S_IDLE);
  assign busy      = (state == S_ACCEL) || (state == S_ADRAIN) ||
                     (state == S_POS)   || (state == S_PDRAIN);
  assign n_m1      = n_bodies - (BW+1)'(1);
  assign ci_last   = ({1'b0, ci} == n_m1);
  assign cj_last   = ({1'b0, cj} == n_m1);
  assign steps_eff = (steps == 16'd0) ? 16'd1 : steps;
  assign n_clamp   = (bus.writedata > DATA_WIDTH'(BODIES)) ? (BW+1)'(BODIES) : bus.writedata[BW:0];

  assign pair_valid   = (state == S_ACCEL);
  assign pair_i       = pair_valid ? ci : '0;
  assign pair_j       = pair_valid ? cj : '0;
  assign pair_last    = pair_valid && cj_last;
  assign pos_rd_valid = (state == S_POS);
  assign pos_rd_addr  = pos_rd_valid ? ci : '0;

  assign v_wren      = v_vld[ACCEL_LAT];
  assign v_wr_addr   = v_adr[ACCEL_LAT];
  assign pos_wren    = p_vld[POS_LAT];
  assign pos_wr_addr = p_adr[POS_LAT];

  // Only the j=N-1 pair of each row produces a velocity write; rows retire in order.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      v_vld <= '0;
      v_adr <= '0;
      p_vld <= '0;
      p_adr <= '0;
    end else begin
      v_vld[1] <= pair_last;
      v_adr[1] <= ci;
      for (int k = 2; k <= ACCEL_LAT; k++) begin
        v_vld[k] <= v_vld[k-1];
        v_adr[k] <= v_adr[k-1];
      end
      p_vld[1] <= pos_rd_valid;
      p_adr[1] <= ci;
      for (int k = 2; k <= POS_LAT; k++) begin
        p_vld[k] <= p_vld[k-1];
        p_adr[k] <= p_adr[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      go         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      first_step <= 1'b0;
      n_bodies   <= '0;
      steps      <= 16'd1;
      step_count <= '0;
      ci         <= '0;
      cj         <= '0;
    end else begin
      case (state)
        S_IDLE: if (go && !done) begin
          if (n_bodies != '0) begin
            state      <= S_ACCEL;
            ci         <= '0;
            cj         <= '0;
            first_step <= 1'b1;
            step_count <= '0;
            err        <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
        S_ACCEL: begin
          if (cj_last) begin
            cj <= '0;
            if (ci_last) begin
              ci    <= '0;
              state <= S_ADRAIN;
            end else begin
              ci <= ci + 1'b1;
            end
          end else begin
            cj <= cj + 1'b1;
          end
        end
        S_ADRAIN: if (v_wren && ({1'b0, v_wr_addr} == n_m1)) begin
          state <= S_POS;
          ci    <= '0;
        end
        S_POS: begin
          if (ci_last) begin
            ci    <= '0;
            state <= S_PDRAIN;
          end else begin
            ci <= ci + 1'b1;
          end
        end
        S_PDRAIN: if (pos_wren && ({1'b0, pos_wr_addr} == n_m1)) begin
          step_count <= step_count + 16'd1;
          first_step <= 1'b0;
          if (step_count + 16'd1 >= steps_eff) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ACCEL;
          end
        end
        S_DONE: if (ack) begin
          state      <= S_IDLE;
          step_count <= '0;
        end
        default: state <= S_IDLE;
      endcase

      // Register writes follow the FSM so an ACK in the same cycle wins over a fresh err/done.
      if (wr) begin
        case (bus.addr[2:0])
          3'd0: begin
            go <= bus.writedata[0];
            if (bus.writedata[1]) begin
              done <= 1'b0;
              err  <= 1'b0;
              if (!busy) step_count <= '0;
            end
          end
          3'd2: if (!busy) n_bodies <= n_clamp;
          3'd3: if (!busy) steps <= bus.writedata[15:0];
          default: ;
        endcase
      end

      if (abort) begin
        state      <= S_IDLE;
        ci         <= '0;
        cj         <= '0;
        first_step <= 1'b0;
      end
    end
  end

`ifdef NBODY_SCHED_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk) begin
    if (rst) irq_en <= 1'b0;
    else if (wr && (bus.addr[2:0] == 3'd5)) irq_en <= bus.writedata[0];
  end
  assign irq = done & irq_en;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '1;
    case (bus.addr[2:0])
      3'd0: rd_mux = DATA_WIDTH'(go);
      3'd1: rd_mux = DATA_WIDTH'({first_step, err, done, busy});
      3'd2: rd_mux = DATA_WIDTH'(n_bodies);
      3'd3: rd_mux = DATA_WIDTH'(steps);
      3'd4: rd_mux = DATA_WIDTH'(step_count);
`ifdef NBODY_SCHED_IRQ_EN
      3'd5: rd_mux = DATA_WIDTH'(irq_en);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     bus.readdata <= '0;
    else if (rd) bus.readdata <= rd_mux;
  end
endmodule

// File: tb/tb_nbody_sched.sv
// Directed bench for nbody_sched (BODIES=8, ACCEL_LAT=4, POS_LAT=2) with a latency/order monitor.
module tb_nbody_sched;
  localparam int BODIES = 8;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int AL = 4;
  localparam int PL = 2;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nbody_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  logic [BW-1:0] pair_i, pair_j, v_wr_addr, pos_rd_addr, pos_wr_addr;
  logic pair_valid, pair_last, v_wren, pos_rd_valid, pos_wren, first_step, irq;

  nbody_sched #(.BODIES(BODIES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCEL_LAT(AL), .POS_LAT(PL)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pair_i(pair_i), .pair_j(pair_j), .pair_valid(pair_valid), .pair_last(pair_last),
    .v_wr_addr(v_wr_addr), .v_wren(v_wren),
    .pos_rd_addr(pos_rd_addr), .pos_rd_valid(pos_rd_valid),
    .pos_wr_addr(pos_wr_addr), .pos_wren(pos_wren),
    .first_step(first_step), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic bwr(input int a, input logic [63:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.addr = AW'(a); bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic brd(input int a, output logic [63:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.addr = AW'(a);
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic wait_done(input string tag);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 2000; k++) begin
      brd(1, s);
      if (s[1]) break;
    end
    chk(tag, 64'(s[1]), 1);
  endtask

  // Monitor: every strobe must match an earlier issue exactly LAT cycles back, in order.
  typedef struct { int c; int a; } ent_t;
  ent_t vq[$];
  ent_t pq[$];
  ent_t ev, ep;
  logic [5:0] pairs[$];
  int cyc = 0, n_pair = 0, n_last = 0, n_vw = 0, n_pw = 0, n_fs = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      vq.delete();
      pq.delete();
    end else begin
      if (pair_valid) begin
        n_pair++;
        pairs.push_back({pair_i, pair_j});
        if (first_step) n_fs++;
        if (pair_last) begin
          n_last++;
          vq.push_back('{cyc, int'(pair_i)});
        end
      end
      if (pos_rd_valid) pq.push_back('{cyc, int'(pos_rd_addr)});
      if (v_wren) begin
        n_vw++;
        if (vq.size() == 0) chk("v_wren_unexpected", 64'(v_wren), 0);
        else begin
          ev = vq.pop_front();
          chk("v_wren_lat", 64'(cyc - ev.c), AL);
          chk("v_wr_addr", 64'(v_wr_addr), 64'(ev.a));
        end
      end
      if (pos_wren) begin
        n_pw++;
        if (pq.size() == 0) chk("pos_wren_unexpected", 64'(pos_wren), 0);
        else begin
          ep = pq.pop_front();
          chk("pos_wren_lat", 64'(cyc - ep.c), PL);
          chk("pos_wr_addr", 64'(pos_wr_addr), 64'(ep.a));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [5:0]  exp_p;
    int b_pair, b_vw, b_pw, b_fs, b_last, base, k;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.writedata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 0);
    chk("rst_outputs", {pair_valid, pair_last, v_wren, pos_rd_valid, pos_wren, first_step, irq}, 0);
    rst = 1'b0;
    brd(1, d); chk("rst_status", d, 0);
    brd(2, d); chk("rst_nbodies", d, 0);
    brd(3, d); chk("rst_steps", d, 1);
    brd(4, d); chk("rst_stepcount", d, 0);
    brd(6, d); chk("unmapped_6", d, 64'hFFFF_FFFF_FFFF_FFFF);

    // clamp and zero-body error
    bwr(2, 20); brd(2, d); chk("nbodies_clamp", d, 8);
    bwr(2, 0);
    b_pair = n_pair;
    bwr(0, 1);
    repeat (4) @(negedge clk);
    brd(1, d); chk("err_n0_status", d, 4);
    chk("err_n0_pairs", 64'(n_pair - b_pair), 0);
    bwr(0, 2); brd(1, d); chk("err_ack_status", d, 0);

    // N=3, one step
    bwr(2, 3); bwr(3, 1);
    b_pair = n_pair; b_vw = n_vw; b_pw = n_pw; b_last = n_last; base = pairs.size();
    bwr(0, 1);
    wait_done("n3_done");
    chk("n3_pairs", 64'(n_pair - b_pair), 9);
    chk("n3_last", 64'(n_last - b_last), 3);
    chk("n3_vwren", 64'(n_vw - b_vw), 3);
    chk("n3_poswren", 64'(n_pw - b_pw), 3);
    for (int p = 0; p < 9; p++) begin
      exp_p = {3'(p / 3), 3'(p % 3)};
      chk("n3_pair_order", 64'(pairs[base + p]), 64'(exp_p));
    end
    brd(1, d); chk("n3_status_done", d, 2);
    brd(4, d); chk("n3_stepcount", d, 1);
    chk("n3_irq_off", 64'(irq), 0);
    bwr(5, 1);
`ifdef NBODY_SCHED_IRQ_EN
    chk("irq_set", 64'(irq), 1);
    brd(5, d); chk("irq_en_read", d, 1);
`else
    chk("irq_tied", 64'(irq), 0);
    brd(5, d); chk("reg5_unmapped", d, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    bwr(0, 2);
    chk("ack_irq", 64'(irq), 0);
    brd(1, d); chk("ack_status", d, 0);
    brd(4, d); chk("ack_stepcount", d, 0);

    // N=2, three steps, first_step only on step 1
    bwr(2, 2); bwr(3, 3);
    b_pair = n_pair; b_fs = n_fs;
    bwr(0, 1);
    wait_done("n2_done");
    chk("n2_pairs", 64'(n_pair - b_pair), 12);
    chk("n2_first_step_pairs", 64'(n_fs - b_fs), 4);
    brd(4, d); chk("n2_stepcount", d, 3);
    brd(1, d); chk("n2_status_done", d, 2);
    bwr(0, 3);
    @(negedge clk);
    chk("restart_pair_valid", 64'(pair_valid), 1);
    chk("restart_first_step", 64'(first_step), 1);
    bwr(0, 0);
    chk("restart_abort", 64'(pair_valid), 0);
    brd(1, d); chk("restart_abort_status", d, 0);

    // abort on the third pair of N=4
    bwr(2, 4); bwr(3, 1);
    b_pair = n_pair; b_vw = n_vw; b_pw = n_pw;
    bwr(0, 1);
    k = 0;
    while (!pair_valid && k < 20) begin @(negedge clk); k++; end
    chk("abort_started", 64'(pair_valid), 1);
    repeat (2) @(negedge clk);
    chk("abort_third_j", 64'(pair_j), 2);
    bwr(0, 0);
    chk("abort_idle", 64'(pair_valid), 0);
    repeat (20) @(negedge clk);
    chk("abort_pairs", 64'(n_pair - b_pair), 3);
    chk("abort_vwren", 64'(n_vw - b_vw), 0);
    chk("abort_poswren", 64'(n_pw - b_pw), 0);
    brd(1, d); chk("abort_status", d, 0);

    // reset during POS_DRAIN, N=5
    bwr(2, 5); bwr(3, 1); bwr(0, 1);
    k = 0;
    while (!pos_rd_valid && k < 300) begin @(negedge clk); k++; end
    chk("n5_pos_seen", 64'(pos_rd_valid), 1);
    k = 0;
    while (pos_rd_valid && k < 20) begin @(negedge clk); k++; end
    chk("n5_pos_drain", 64'(pos_rd_valid), 0);
    rst = 1'b1;
    b_pw = n_pw; b_vw = n_vw;
    @(negedge clk);
    chk("rst_mid_strobes", {pair_valid, pair_last, v_wren, pos_rd_valid, pos_wren, first_step, irq}, 0);
    chk("rst_mid_addrs", {pair_i, pair_j, v_wr_addr, pos_rd_addr, pos_wr_addr}, 0);
    chk("rst_mid_readdata", bus.readdata, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_poswren", 64'(n_pw - b_pw), 0);
    chk("rst_mid_no_vwren", 64'(n_vw - b_vw), 0);
    brd(1, d); chk("rst_mid_status", d, 0);
    brd(2, d); chk("rst_mid_nbodies", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nbody_sched.md
NBODY_SCHED -- requirements
Module: nbody_sched

Interface
REQ-001 SHALL have parameter BODIES, default 512: maximum body count.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: bus data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: bus address width.
REQ-004 SHALL have parameter ACCEL_LAT, default 78: cycles from pair issue to its velocity write strobe.
REQ-005 SHALL have parameter POS_LAT, default 21: cycles from position read issue to its position write strobe.
REQ-006 SHALL have derived localparam BW = $clog2(BODIES).
REQ-007 SHALL have port clk, input, 1: sole clock; rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have bus ports: chipselect in 1; read in 1; write in 1; addr in ADDR_WIDTH; writedata in DATA_WIDTH; readdata out DATA_WIDTH.
REQ-009 SHALL have pair ports: pair_i out BW; pair_j out BW; pair_valid out 1; pair_last out 1 (j is the last body).
REQ-010 SHALL have velocity ports: v_wr_addr out BW; v_wren out 1.
REQ-011 SHALL have position ports: pos_rd_addr out BW; pos_rd_valid out 1; pos_wr_addr out BW; pos_wren out 1.
REQ-012 SHALL have status ports: first_step out 1 (half-kick step); irq out 1.

Function
REQ-013 SHALL decode registers from addr[2:0] when chipselect=1: 0 CTRL (bit0 GO, bit1 ACK write-1-to-clear); 1 STATUS RO (bit0 busy, bit1 done, bit2 err, bit3 first_step); 2 N_BODIES (BW+1 bits); 3 STEPS (16 bits); 4 STEP_COUNT RO; 5 IRQ_EN.
REQ-014 SHALL return readdata one cycle after read with chipselect=1, zero-extended; unmapped index returns all ones.
REQ-015 SHALL clamp N_BODIES writes above BODIES to BODIES; STEPS=0 SHALL behave as 1.
REQ-016 SHALL implement states IDLE, ACCEL, ACCEL_DRAIN, POS, POS_DRAIN, DONE.
REQ-017 IDLE->ACCEL when GO=1, done=0, N_BODIES>=1; GO=1 with N_BODIES=0 SHALL set err, stay IDLE.
REQ-018 ACCEL SHALL issue one pair per cycle, i-major, j fastest, (0,0)..(N-1,N-1); pair_valid=1; pair_last=1 when j=N-1.
REQ-019 v_wren SHALL pulse exactly ACCEL_LAT cycles after each issue with pair_last=1, v_wr_addr = that pair's i.
REQ-020 ACCEL->ACCEL_DRAIN after last pair issued; ACCEL_DRAIN->POS the cycle after the final v_wren.
REQ-021 POS SHALL issue pos_rd_addr 0..N-1, one per cycle, pos_rd_valid=1; pos_wren pulses POS_LAT cycles after each with pos_wr_addr = issued address.
REQ-022 POS->POS_DRAIN after address N-1; POS_DRAIN exits the cycle after final pos_wren, incrementing STEP_COUNT.
REQ-023 After POS_DRAIN: STEP_COUNT=STEPS -> DONE (done=1, busy=0); otherwise -> ACCEL.
REQ-024 first_step SHALL be 1 throughout the first step after a start, 0 on later steps.
REQ-025 DONE SHALL hold until ACK written; ACK clears done and STEP_COUNT, -> IDLE; GO still 1 restarts next cycle.
REQ-026 Writing GO=0 in any non-IDLE state SHALL -> IDLE next cycle, flush delay lines; no further v_wren/pos_wren.
REQ-027 busy SHALL be 1 in ACCEL through POS_DRAIN; writes to N_BODIES/STEPS while busy SHALL be ignored.
REQ-028 Simultaneous ACK and GO=0 write: both apply; result IDLE, done=0.

Reset
REQ-029 rst=1 SHALL force IDLE, all outputs 0 (readdata 0), GO=0, done=0, err=0, N_BODIES=0, STEPS=1, STEP_COUNT=0, IRQ_EN=0, delay lines flushed.
REQ-030 rst mid-step SHALL suppress all strobes from the next cycle.

Configuration
REQ-031 With NBODY_SCHED_IRQ_EN defined: irq = done AND IRQ_EN, level, cleared by ACK.
REQ-032 Without NBODY_SCHED_IRQ_EN: irq tied 0; register 5 unmapped (reads all ones, writes ignored).

Verification (BODIES=8, ACCEL_LAT=4, POS_LAT=2)
REQ-033 N=3, STEPS=1, GO -> 9 pair_valid cycles, v_wren for i=0,1,2 at 4 cycles after each pair_last, 3 pos_wren, done=1, STEP_COUNT=1.
REQ-034 N=2, STEPS=3 -> first_step=1 only in step 1; STEP_COUNT reads 3 at DONE; 12 pair_valid total.
REQ-035 N_BODIES write 20 -> reads back 8; N=0 then GO -> err=1, no pair_valid.
REQ-036 GO=0 written at 3rd pair of N=4 -> IDLE next cycle, zero v_wren/pos_wren afterwards.
REQ-037 DONE, IRQ_EN=1, macro defined -> irq=1; ACK -> irq=0, done=0, STEP_COUNT=0; macro undefined -> irq=0, reg 5 reads all ones.
REQ-038 rst asserted in POS_DRAIN with N=5 -> all outputs 0 next cycle, STATUS reads 0.
